// File: rtl/regfile_wb_scheduler.sv
// Writeback arbiter for two result producers (ALU, LSU) feeding one
// register-file write port, with a pending-write scoreboard for dispatch.
module regfile_wb_scheduler #(
    parameter int XLEN = 64,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rd,
    input  logic [4:0]      issue_rs1,
    input  logic [4:0]      issue_rs2,
    output logic            issue_stall,
    input  logic            req0_valid,
    input  logic [4:0]      req0_rd,
    input  logic [XLEN-1:0] req0_data,
    output logic            req0_ready,
    input  logic            req1_valid,
    input  logic [4:0]      req1_rd,
    input  logic [XLEN-1:0] req1_data,
    output logic            req1_ready,
    output logic            rf_wr_en,
    output logic [4:0]      rf_wr_addr,
    output logic [XLEN-1:0] rf_wr_data,
    output logic [NREG-1:0] pending,
    output logic            sb_error
);

    logic            last1_q, last1_d;
    logic            wr_en_q, wr_en_d;
    logic [4:0]      wr_addr_q, wr_addr_d;
    logic [XLEN-1:0] wr_data_q, wr_data_d;
    logic [NREG-1:0] pending_q, pending_d;
    logic            err_q, err_d;

    logic            gnt0, gnt1, hs, hazard;
    logic [4:0]      hs_rd;
    logic [XLEN-1:0] hs_data;

    always_comb begin
        // last1_q high means req1 won last, so req0 wins the next tie
        gnt0 = !reset && req0_valid && (!req1_valid || last1_q);
        gnt1 = !reset && req1_valid && !gnt0;
        hs = gnt0 || gnt1;
        hs_rd = gnt0 ? req0_rd : req1_rd;
        hs_data = gnt0 ? req0_data : req1_data;

        hazard = ((issue_rs1 != 5'd0) && pending_q[issue_rs1])
              || ((issue_rs2 != 5'd0) && pending_q[issue_rs2])
              || ((issue_rd != 5'd0) && pending_q[issue_rd]);
        issue_stall = !reset && issue_valid && hazard;

        last1_d = hs ? gnt1 : last1_q;
        wr_en_d = hs && (hs_rd != 5'd0);
        wr_addr_d = wr_en_d ? hs_rd : wr_addr_q;
        wr_data_d = wr_en_d ? hs_data : wr_data_q;
        err_d = err_q || (wr_en_d && !pending_q[hs_rd]);

        pending_d = pending_q;
        if (wr_en_q)
            pending_d[wr_addr_q] = 1'b0;
        if (issue_valid && !issue_stall && (issue_rd != 5'd0))
            pending_d[issue_rd] = 1'b1;
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last1_q   <= 1'b1;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            pending_q <= '0;
            err_q     <= 1'b0;
        end else begin
            last1_q   <= last1_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            pending_q <= pending_d;
            err_q     <= err_d;
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign rf_wr_en   = wr_en_q;
    assign rf_wr_addr = wr_addr_q;
    assign rf_wr_data = wr_data_q;
    assign pending    = pending_q;
    assign sb_error   = err_q;

endmodule

// File: doc/regfile_wb_scheduler.md
REGFILE_WB_SCHEDULER -- requirements
Module: regfile_wb_scheduler

Interface
REQ-001 Parameter XLEN, default 64, SHALL set the register data width.
REQ-002 Parameter NREG, default 32, SHALL set the register count; register addresses are 5 bits.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 issue_valid  input  1  SHALL mean an instruction is presented for dispatch.
REQ-006 issue_rd, issue_rs1, issue_rs2  input  5 each  SHALL carry the dispatching instruction's destination and source registers.
REQ-007 issue_stall  output  1  SHALL mean the dispatch cannot be accepted this cycle.
REQ-008 req0_valid / req1_valid  input  1  SHALL mean writeback requester 0 (ALU) or 1 (LSU) holds a result.
REQ-009 req0_rd / req1_rd  input  5  SHALL carry the destination register of each requester.
REQ-010 req0_data / req1_data  input  XLEN  SHALL carry the result data of each requester.
REQ-011 req0_ready / req1_ready  output  1  SHALL be the grant; handshake completes when valid and ready are both high.
REQ-012 rf_wr_en  output  1  SHALL drive the register file write enable.
REQ-013 rf_wr_addr  output  5  SHALL drive the register file write address.
REQ-014 rf_wr_data  output  XLEN  SHALL drive the register file write data.
REQ-015 pending  output  NREG  SHALL expose the scoreboard; bit n means a write to register n is outstanding.
REQ-016 sb_error  output  1  SHALL be a sticky flag for a writeback to a non-pending register.

Function
REQ-017 Arbitration: at most one of req0_ready/req1_ready SHALL be high per cycle; readies are combinational from current valids and arbitration state.
REQ-018 If exactly one requester is valid, it SHALL be granted that cycle.
REQ-019 If both are valid, the requester not granted most recently SHALL be granted (round-robin).
REQ-020 The round-robin pointer SHALL update only on a completed handshake.
REQ-021 Requesters SHALL hold valid, rd and data stable until granted; the block need not tolerate otherwise.
REQ-022 Write port: the handshake in cycle N SHALL produce rf_wr_en=1 with the granted rd and data in cycle N+1 (registered, 1-cycle latency).
REQ-023 A cycle with no handshake SHALL produce rf_wr_en=0 in the next cycle; rf_wr_addr/rf_wr_data hold their last values.
REQ-024 A handshake with rd=0 SHALL complete normally but SHALL produce rf_wr_en=0 (x0 write discarded).
REQ-025 Scoreboard clear: pending[rf_wr_addr] SHALL clear at the clock edge ending a cycle where rf_wr_en=1.
REQ-026 issue_stall SHALL equal issue_valid AND any of: pending[issue_rs1] with rs1!=0, pending[issue_rs2] with rs2!=0, pending[issue_rd] with rd!=0 (RAW and WAW); no forwarding; current-cycle pending is used.
REQ-027 Scoreboard set: issue_valid=1 and issue_stall=0 with issue_rd!=0 SHALL set pending[issue_rd] at the next edge.
REQ-028 pending[0] SHALL be constant 0.
REQ-029 Set and clear of the same bit in one cycle cannot occur given REQ-026; clear of register A and set of register B in the same cycle SHALL both take effect.
REQ-030 A handshake with rd!=0 whose rd is not pending SHALL still write, and SHALL set sb_error, which stays high until reset.

Reset
REQ-031 While reset is high: pending=0, rf_wr_en=0, rf_wr_addr=0, rf_wr_data=0, and sb_error=0; the round-robin pointer SHALL favour req0 on the first contention.
REQ-032 While reset is high, req0_ready and req1_ready SHALL be 0 and issue_stall SHALL be 0.
REQ-033 Reset asserted mid-operation SHALL drop any registered write not yet presented, and SHALL take effect at the next edge.

Verification
REQ-034 Dispatch rd=5, then next cycle dispatch rs1=5 -> issue_stall=1 until the cycle after rf_wr_en=1 with rf_wr_addr=5; pending[5] is 0 thereafter.
REQ-035 req0 and req1 valid simultaneously for 4 cycles after reset (rd=3, rd=4) -> grants req0, req1, then the bench re-presents both -> req0, req1; rf_wr_en=1 on each following cycle.
REQ-036 req1_valid with rd=0 and data=0xDEAD -> req1_ready=1 and rf_wr_en stays 0 the next cycle.
REQ-037 req0 writes rd=7 with pending[7]=0 -> register written and sb_error=1 and held until reset.
REQ-038 Dispatch rd=9 and a writeback for rd=2 (pending) in the same cycle -> pending[9]=1 and pending[2]=0 after the edge(s) per REQ-025/027.
REQ-039 Assert reset for one cycle with pending=0x0000_0F00 and a grant in flight -> pending=0, rf_wr_en=0, sb_error=0 the next cycle.
